mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 clk  in  1  rising-edge clock; the block uses one clock only.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 in_valid  in  1  EX/MEM register holds a live instruction.
REQ-004 addr  in  32  ALU result: byte address for memory ops, writeback data otherwise.
REQ-005 wdata  in  32  store data (rt value).
REQ-006 MemWrite  in  1  store op.
REQ-007 MemToReg  in  1  load op; writeback comes from memory.
REQ-008 RegWrite  in  1  register-file write enable.
REQ-009 ExtrWord  in  2  load size: 00 = word, 01 = halfword, 10 = byte; 11 is treated as word.
REQ-010 ExtrSigned  in  1  1 = sign-extend load, 0 = zero-extend.
REQ-011 Sh  in  1  halfword store.
REQ-012 Sb  in  1  byte store; Sb has priority over Sh.
REQ-013 write  in  6  destination register index.
REQ-014 stall  out  1  combinational; holds EX/MEM and upstream stages.
REQ-015 dmem_req  out  1  registered memory request.
REQ-016 dmem_we  out  1  registered write enable.
REQ-017 dmem_be  out  4  registered byte enables, little-endian.
REQ-018 dmem_addr  out  32  registered word address; bits [1:0] = 00.
REQ-019 dmem_wdata  out  32  registered lane-replicated store data.
REQ-020 dmem_rdata  in  32  read word; valid on the cycle dmem_ack is high.
REQ-021 dmem_ack  in  1  memory completion; single-cycle pulse.
REQ-022 wb_valid  out  1  registered; writeback bundle is valid.
REQ-023 wb_data  out  32  registered writeback value.
REQ-024 wb_write  out  6  registered destination index.
REQ-025 wb_RegWrite  out  1  registered register-file write enable.

Function
REQ-026 The FSM SHALL have three states: IDLE, REQ, RESP.
REQ-027 A memory op is accepted in IDLE when in_valid && (MemWrite || MemToReg); on acceptance the block SHALL latch addr, wdata, the control signals and write, assert stall in that cycle, and enter REQ.
REQ-028 In REQ, dmem_req SHALL be 1 and dmem_addr/we/be/wdata SHALL stay stable until dmem_ack is sampled 1; the block then captures dmem_rdata and enters RESP.
REQ-029 In RESP, stall SHALL be 0, the wb_* registers SHALL be loaded with the completed op, and the FSM SHALL return to IDLE; back-to-back memory ops therefore cost at least 3 cycles each.
REQ-030 stall SHALL equal (IDLE && accept) || REQ.
REQ-031 For an ack k cycles after dmem_req rises (k >= 0, so k = 0 means ack in the first REQ cycle), stall SHALL be high for k+2 cycles and wb_valid SHALL rise k+2 cycles after acceptance.
REQ-032 A non-memory op in IDLE (in_valid=1, MemWrite=MemToReg=0) SHALL be passed through in 1 cycle: wb_data=addr, wb_write=write, wb_RegWrite=RegWrite, wb_valid=1, no stall.
REQ-033 With in_valid=0 in IDLE, wb_valid and wb_RegWrite SHALL be 0 on the next cycle.
REQ-034 Byte-enable generation:
- Sb: dmem_be = 1 << addr[1:0], wdata[7:0] replicated ×4.
- Sh: dmem_be = addr[1] ? 1100 : 0011, wdata[15:0] replicated ×2.
- Word: dmem_be = 1111.
- Loads: dmem_be = 1111, dmem_we = 0.
REQ-035 Load extraction:
- Byte: select rdata[8*addr[1:0] +: 8].
- Halfword: select rdata[16*addr[1] +: 16].
- Then extend to 32 bits per ExtrSigned.
REQ-036 Stores SHALL complete with wb_RegWrite = RegWrite as presented (normally 0).
REQ-037 dmem_ack SHALL be ignored in IDLE and RESP.

Reset
REQ-038 When rst is 1 at a clock edge: state = IDLE and every registered output = 0.
REQ-039 Reset during REQ SHALL abandon the access: dmem_req = 0 from the next cycle, and a late ack is ignored.

Configuration
REQ-040 When MEM_ALIGN_CHECK_EN is defined:
- An output wb_exc (1 bit, registered) is added.
- A misaligned halfword (addr[0]=1) or word (addr[1:0]≠0) access SHALL NOT raise dmem_req.
- The op goes IDLE→RESP, giving 1 stall cycle, with wb_exc=1 and wb_RegWrite=0.
REQ-041 When MEM_ALIGN_CHECK_EN is undefined: no wb_exc port exists, low address bits are ignored for alignment, and the access is performed at the truncated address.

Structure
REQ-042 Package mem_pkg SHALL hold the ExtrWord encodings (EW_WORD, EW_HALF, EW_BYTE), the state encoding, and DATA_BITS = 32.
REQ-043 Sub-module load_extract (combinational: rdata, addr[1:0], ExtrWord, ExtrSigned → 32-bit value) SHALL be instantiated once.

Verification
REQ-044 Load byte, addr=0x1003, ExtrSigned=1, rdata=0x80AABBCC, ack k=2 → wb_data=0xFFFFFF80 and 4 stall cycles.
REQ-045 Sh, addr=0x2002, wdata=0x1234ABCD → dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x2000, dmem_we=1.
REQ-046 ALU op, addr=0x55, write=5, RegWrite=1 → next cycle wb_valid=1, wb_data=0x55, stall never high.
REQ-047 rst asserted in REQ, then ack one cycle later → dmem_req=0, wb_valid=0, FSM IDLE.
REQ-048 Load word at 0x1002: with MEM_ALIGN_CHECK_EN → no dmem_req, wb_exc=1; without it → dmem_addr=0x1000.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared load-size encodings, FSM state type and datapath width for mem_access_stage
package mem_pkg;
  localparam int DATA_BITS = 32;
  localparam logic [1:0] EW_WORD = 2'b00;
  localparam logic [1:0] EW_HALF = 2'b01;
  localparam logic [1:0] EW_BYTE = 2'b10;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/load_extract.sv
// load_extract: picks the addressed byte/halfword lane of a read word and sign- or zero-extends it
module load_extract
  import mem_pkg::*;
(
  input  logic [DATA_BITS-1:0] rdata,
  input  logic [1:0]           addr_lo,
  input  logic [1:0]           extr_word,
  input  logic                 extr_signed,
  output logic [DATA_BITS-1:0] value
);
  logic [7:0] b;
  logic [15:0] h;
  // lane select, then extension; EW 11 falls through to a full word
  always_comb begin
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = rdata[{addr_lo[1], 4'b0000} +: 16];
    value = extr_word == EW_BYTE ? {{24{extr_signed & b[7]}}, b} :
            extr_word == EW_HALF ? {{16{extr_signed & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with IDLE/REQ/RESP memory handshake; optional MEM_ALIGN_CHECK_EN adds wb_exc
module mem_access_stage
  import mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 MemWrite,
  input  logic                 MemToReg,
  input  logic                 RegWrite,
  input  logic [1:0]           ExtrWord,
  input  logic                 ExtrSigned,
  input  logic                 Sh,
  input  logic                 Sb,
  input  logic [5:0]           write,
  output logic                 stall,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [3:0]           dmem_be,
  output logic [DATA_BITS-1:0] dmem_addr,
  output logic [DATA_BITS-1:0] dmem_wdata,
  input  logic [DATA_BITS-1:0] dmem_rdata,
  input  logic                 dmem_ack,
  output logic                 wb_valid,
  output logic [DATA_BITS-1:0] wb_data,
  output logic [5:0]           wb_write,
  output logic                 wb_RegWrite
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                 wb_exc
`endif
);
  state_t state;
  logic [DATA_BITS-1:0] addr_q, res_q, ext, wd;
  logic [1:0] ew_q;
  logic [5:0] write_q;
  logic to_reg_q, reg_write_q, signed_q, exc_q, accept, misaligned;
  logic [3:0] be;
  load_extract u_extract (
    .rdata(dmem_rdata),
    .addr_lo(addr_q[1:0]),
    .extr_word(ew_q),
    .extr_signed(signed_q),
    .value(ext)
  );
  // acceptance, stall and store lane formatting for the op held in EX/MEM
  always_comb begin
    accept = state == IDLE && in_valid && (MemWrite || MemToReg);
    stall = accept || state == REQ;
    be = !MemWrite ? 4'hf : Sb ? 4'b0001 << addr[1:0] : Sh ? (addr[1] ? 4'b1100 : 4'b0011) : 4'hf;
    wd = Sb ? {4{wdata[7:0]}} : Sh ? {2{wdata[15:0]}} : wdata;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = MemWrite ? !Sb && (Sh ? addr[0] : |addr[1:0]) :
                 ExtrWord == EW_BYTE ? 1'b0 : ExtrWord == EW_HALF ? addr[0] : |addr[1:0];
`else
    misaligned = 1'b0;
`endif
  end
  // handshake FSM; wb_* pulse for one cycle on pass-through or on leaving RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_be <= '0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_data <= '0;
      wb_write <= '0;
      wb_RegWrite <= 1'b0;
      exc_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      wb_exc <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
      wb_RegWrite <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      wb_exc <= 1'b0;
`endif
      if (state == IDLE) begin
        if (accept) begin
          state <= misaligned ? RESP : REQ;
          dmem_req <= !misaligned;
          dmem_we <= MemWrite && !misaligned;
          dmem_be <= be;
          dmem_addr <= {addr[DATA_BITS-1:2], 2'b00};
          dmem_wdata <= wd;
          addr_q <= addr;
          res_q <= addr;
          to_reg_q <= MemToReg && !MemWrite;
          reg_write_q <= RegWrite;
          signed_q <= ExtrSigned;
          ew_q <= ExtrWord;
          write_q <= write;
          exc_q <= misaligned;
        end else begin
          wb_valid <= in_valid;
          wb_RegWrite <= in_valid && RegWrite;
          wb_data <= addr;
          wb_write <= write;
        end
      end else if (state == REQ) begin
        if (dmem_ack) begin
          state <= RESP;
          dmem_req <= 1'b0;
          dmem_we <= 1'b0;
          res_q <= to_reg_q ? ext : addr_q;
        end
      end else begin
        state <= IDLE;
        wb_valid <= 1'b1;
        wb_data <= res_q;
        wb_write <= write_q;
        wb_RegWrite <= reg_write_q && !exc_q;
`ifdef MEM_ALIGN_CHECK_EN
        wb_exc <= exc_q;
`endif
      end
    end
  end
endmodule
